decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Pipelined, back-pressured successor of the single-cycle decoder. Decodes the 9-bit
//  ISA into type/funct/regs/imm/control fields. Sits between fetch (in_*) and
//  execute (out_*) with valid/ready handshakes on both sides. Adds an optional
//  2-entry skid buffer, flush for taken branches and a RUN/HALTED state machine.
// PARAMETERS
//  PC_W   8  width of PC carried alongside each instruction
//  IMM_W  6  width of out_imm; decoded immediates zero-extended (IMM_W >= 6)
//  SKID   1  1: 2-entry skid buffer, in_ready registered; 0: single output register
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      fetch presents in_inst/in_pc
//  in_ready   out  1      decoder accepts this cycle (accept = in_valid & in_ready)
//  in_inst    in   9      instruction word
//  in_pc      in   PC_W   PC of in_inst
//  cmp        in   1      compare flag, sampled in the accept cycle
//  flush      in   1      drop all buffered and same-cycle-accepted instructions
//  out_valid  out  1      decoded entry valid at head
//  out_ready  in   1      execute consumes head (pop = out_valid & out_ready)
//  out_pc     out  PC_W   PC of head entry
//  out_type   out  3      1 ALU, 2 ctrl/nop, 3 reg-branch, 4 move, 5 store, 6 load
//  out_funct  out  4      ALU function
//  out_r1     out  2      first register index
//  out_r2     out  2      second register index
//  out_imm    out  IMM_W  immediate, zero-extended
//  out_ctrl   out  9      [0]readx [1]ready [2]hi [3]lo [4]swap [5]y_is_imm [6]branch [7]branchi [8]jump
//  halted     out  1      1 once HALT accepted
// BEHAVIOUR
//  Reset: FSM=RUN, buffer empty; out_valid=0, halted=0, all out_* fields=0; in_ready=0 while rst high.
//  Decode, first match wins; unlisted fields/ctrl bits = 0:
//   111iiiiii jmpi: type2, branchi, jump, imm=i
//   101rriiii movhi: type4, hi, r1=rr, imm=i | 100rriiii movli: same with lo
//   110rriiii andi: type1, readx, y_is_imm, funct=0011, r1=rr, imm=i
//   011drriii shift: type1, readx, y_is_imm, r1=rr, imm=i, funct = d ? 0111 : 1110
//   01011iiii beqi: type2; if cmp: branchi, imm=i
//   000000001 HALT: type2, FSM->HALTED | 0000000xx other: NOP, type2
//   0000011rr incr: type1, readx, y_is_imm, funct=0101, imm=1, r1=rr
//   0000010rr jmp: type3, readx, branch, r1=rr
//   0000001rr beq: readx, r1=rr; cmp ? (type3, branch) : type2
//   else: r1=[3:2], r2=[1:0], readx, ready; [7:4]=1001 type5, 1000 type6,
//         0111 type4+swap, otherwise type1 with funct=[7:4]
//  Latency: accept in cycle N -> entry at head (out_valid=1) in cycle N+1 if buffer was empty.
//  Output fields held stable while out_valid & !out_ready; order strictly FIFO.
//  SKID=1: in_ready = RUN & (occupancy < 2), registered (no comb path from out_ready);
//   full buffer + pop frees one slot, in_ready rises next cycle.
//  SKID=0: in_ready = RUN & (!out_valid | out_ready) (combinational).
//  Simultaneous accept+pop: both occur; occupancy unchanged.
//  flush: buffer empty and out_valid=0 next cycle; same-cycle accept discarded, HALT
//   discarded by flush does not change FSM; flush beats accept and pop.
//  FSM: RUN -(HALT accepted, no flush)-> HALTED. HALTED: in_ready=0, halted=1, buffered
//   entries (incl. HALT entry) still drain; only rst returns to RUN.
//  rst mid-operation: all entries lost immediately, outputs to reset values.
// TESTING
//  add r1,r2 (0_0010_0110), out_ready=1 -> next cycle out_valid=1, type1, funct=0010, r1=1, r2=2, ctrl=0x003
//  beqi 0_1011_0101 with cmp=1 then cmp=0 -> imm=5, ctrl[7]=1; then ctrl=0, type2
//  SKID=1, out_ready=0, push 3 instrs -> 2 accepted, in_ready=0; out_ready=1 -> pops in order, 3rd accepted
//  flush with 2 buffered + in_valid -> next cycle out_valid=0, nothing from that cycle emerges
//  HALT (0_0000_0001) then in_valid held -> HALT emitted type2, halted=1, in_ready stays 0 until rst
//  rst asserted async while 2 entries buffered -> out_valid=0, halted=0 same cycle without clk edge

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Pipelined, back-pressured instruction decoder for the 9-bit ISA. Sits
//   between fetch and execute with valid/ready handshakes on both sides.
//   Decoded entries are held in a small FIFO: two slots when SKID=1, and in
//   practice one slot when SKID=0, because in_ready then requires that the
//   head is empty or leaving. A taken-branch flush drops every buffered entry
//   as well as any entry accepted in the same cycle. A RUN/HALTED state
//   machine stops intake once a HALT instruction has been accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   fetch presents in_inst / in_pc
//   in_ready   decoder accepts this cycle (accept = in_valid & in_ready)
//   in_inst    9-bit instruction word
//   in_pc      PC of in_inst
//   cmp        compare flag, sampled in the accept cycle
//   flush      drop buffered and same-cycle-accepted instructions
//   out_valid  decoded entry present at head
//   out_ready  execute consumes head (pop = out_valid & out_ready)
//   out_pc     PC of head entry
//   out_type   1 ALU, 2 ctrl/nop, 3 reg-branch, 4 move, 5 store, 6 load
//   out_funct  ALU function
//   out_r1     first register index
//   out_r2     second register index
//   out_imm    immediate, zero-extended to IMM_W
//   out_ctrl   [0]readx [1]ready [2]hi [3]lo [4]swap [5]y_is_imm
//              [6]branch [7]branchi [8]jump
//   halted     high once a HALT has been accepted
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int PC_W  = 8,
    parameter int IMM_W = 6,
    parameter bit SKID  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              cmp,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [2:0]        out_type,
    output logic [3:0]        out_funct,
    output logic [1:0]        out_r1,
    output logic [1:0]        out_r2,
    output logic [IMM_W-1:0]  out_imm,
    output logic [8:0]        out_ctrl,
    output logic              halted
);

    // Control-word bit positions
    localparam int C_READX    = 0;
    localparam int C_READY    = 1;
    localparam int C_HI       = 2;
    localparam int C_LO       = 3;
    localparam int C_SWAP     = 4;
    localparam int C_Y_IS_IMM = 5;
    localparam int C_BRANCH   = 6;
    localparam int C_BRANCHI  = 7;
    localparam int C_JUMP     = 8;

    // Instruction classes
    localparam logic [2:0] T_ALU   = 3'd1;
    localparam logic [2:0] T_CTRL  = 3'd2;
    localparam logic [2:0] T_RBR   = 3'd3;
    localparam logic [2:0] T_MOVE  = 3'd4;
    localparam logic [2:0] T_STORE = 3'd5;
    localparam logic [2:0] T_LOAD  = 3'd6;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // One decoded instruction; the immediate is kept at its native 6 bits
    // and widened only at the output.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [2:0]      typ;
        logic [3:0]      funct;
        logic [1:0]      r1;
        logic [1:0]      r2;
        logic [5:0]      imm;
        logic [8:0]      ctrl;
    } entry_t;

    state_t      state;
    entry_t      dec;
    logic        dec_halt;
    entry_t      mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic        accept;
    logic        push;
    logic        pop;
    logic        halt_take;
    entry_t      head;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    // NOTE: every field gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        dec      = '0;
        dec.pc   = in_pc;
        dec_halt = 1'b0;
        casez (in_inst)
            9'b111??????: begin                     // jmpi
                dec.typ            = T_CTRL;
                dec.ctrl[C_BRANCHI] = 1'b1;
                dec.ctrl[C_JUMP]    = 1'b1;
                dec.imm            = in_inst[5:0];
            end
            9'b101??????: begin                     // movhi
                dec.typ        = T_MOVE;
                dec.ctrl[C_HI] = 1'b1;
                dec.r1         = in_inst[5:4];
                dec.imm        = {2'b00, in_inst[3:0]};
            end
            9'b100??????: begin                     // movli
                dec.typ        = T_MOVE;
                dec.ctrl[C_LO] = 1'b1;
                dec.r1         = in_inst[5:4];
                dec.imm        = {2'b00, in_inst[3:0]};
            end
            9'b110??????: begin                     // andi
                dec.typ               = T_ALU;
                dec.ctrl[C_READX]     = 1'b1;
                dec.ctrl[C_Y_IS_IMM]  = 1'b1;
                dec.funct             = 4'b0011;
                dec.r1                = in_inst[5:4];
                dec.imm               = {2'b00, in_inst[3:0]};
            end
            9'b011??????: begin                     // shift, bit 5 picks direction
                dec.typ               = T_ALU;
                dec.ctrl[C_READX]     = 1'b1;
                dec.ctrl[C_Y_IS_IMM]  = 1'b1;
                dec.r1                = in_inst[4:3];
                dec.imm               = {3'b000, in_inst[2:0]};
                dec.funct             = in_inst[5] ? 4'b0111 : 4'b1110;
            end
            9'b01011????: begin                     // beqi, only taken when cmp
                dec.typ = T_CTRL;
                if (cmp) begin
                    dec.ctrl[C_BRANCHI] = 1'b1;
                    dec.imm             = {2'b00, in_inst[3:0]};
                end
            end
            9'b0000000??: begin                     // HALT or NOP
                dec.typ  = T_CTRL;
                dec_halt = (in_inst[1:0] == 2'b01);
            end
            9'b0000011??: begin                     // incr
                dec.typ              = T_ALU;
                dec.ctrl[C_READX]    = 1'b1;
                dec.ctrl[C_Y_IS_IMM] = 1'b1;
                dec.funct            = 4'b0101;
                dec.imm              = 6'd1;
                dec.r1               = in_inst[1:0];
            end
            9'b0000010??: begin                     // jmp via register
                dec.typ             = T_RBR;
                dec.ctrl[C_READX]   = 1'b1;
                dec.ctrl[C_BRANCH]  = 1'b1;
                dec.r1              = in_inst[1:0];
            end
            9'b0000001??: begin                     // beq via register
                dec.ctrl[C_READX]   = 1'b1;
                dec.r1              = in_inst[1:0];
                dec.typ             = cmp ? T_RBR : T_CTRL;
                dec.ctrl[C_BRANCH]  = cmp;
            end
            default: begin                          // two-register forms
                dec.r1            = in_inst[3:2];
                dec.r2            = in_inst[1:0];
                dec.ctrl[C_READX] = 1'b1;
                dec.ctrl[C_READY] = 1'b1;
                case (in_inst[7:4])
                    4'b1001: dec.typ = T_STORE;
                    4'b1000: dec.typ = T_LOAD;
                    4'b0111: begin
                        dec.typ          = T_MOVE;
                        dec.ctrl[C_SWAP] = 1'b1;
                    end
                    default: begin
                        dec.typ   = T_ALU;
                        dec.funct = in_inst[7:4];
                    end
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake qualifiers. flush overrides both accept and pop.
    // ------------------------------------------------------------------
    assign accept    = in_valid & in_ready;
    assign push      = accept & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign halt_take = push & dec_halt;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage and pointers
    // ------------------------------------------------------------------
    // NOTE: the two storage slots are reset along with the pointers so that
    // the head fields read as zero straight out of reset; with only two
    // entries this costs nothing worth avoiding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= dec;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RUN / HALTED state machine; only reset leaves HALTED.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (halt_take) state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Input ready: registered from next-cycle state when the skid buffer is
    // present (no path from out_ready), combinational otherwise.
    // ------------------------------------------------------------------
    if (SKID) begin : g_skid
        logic in_ready_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                in_ready_q <= 1'b0;
            end else begin
                in_ready_q <= (state == RUN) && !halt_take && (count_next < 2'd2);
            end
        end
        assign in_ready = in_ready_q;
    end else begin : g_noskid
        assign in_ready = ~rst & (state == RUN) & (~out_valid | out_ready);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign head      = mem[rd_ptr];
    assign out_valid = (count != 2'd0);
    assign out_pc    = head.pc;
    assign out_type  = head.typ;
    assign out_funct = head.funct;
    assign out_r1    = head.r1;
    assign out_r2    = head.r2;
    assign out_imm   = IMM_W'(head.imm);
    assign out_ctrl  = head.ctrl;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage (SKID=1). Expected entries are produced by
//   an independent decode model and queued when the bench sees an accept;
//   they are popped and compared when execute consumes the head. in_ready,
//   out_valid and halted are tracked by a small cycle model as well.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int PC_W  = 8;
    localparam int IMM_W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [8:0]       in_inst = '0;
    logic [PC_W-1:0]  in_pc = '0;
    logic             cmp = 1'b0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PC_W-1:0]  out_pc;
    logic [2:0]       out_type;
    logic [3:0]       out_funct;
    logic [1:0]       out_r1;
    logic [1:0]       out_r2;
    logic [IMM_W-1:0] out_imm;
    logic [8:0]       out_ctrl;
    logic             halted;

    decode_stage #(.PC_W(PC_W), .IMM_W(IMM_W), .SKID(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .cmp       (cmp),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_type  (out_type),
        .out_funct (out_funct),
        .out_r1    (out_r1),
        .out_r2    (out_r2),
        .out_imm   (out_imm),
        .out_ctrl  (out_ctrl),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [2:0]      typ;
        logic [3:0]      funct;
        logic [1:0]      r1;
        logic [1:0]      r2;
        logic [IMM_W-1:0] imm;
        logic [8:0]      ctrl;
    } exp_t;

    typedef struct {
        logic [8:0] inst;
        logic       c;
    } stim_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   m_halted = 1'b0;
    bit   m_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decoder, written from the instruction table as a prefix chain.
    function automatic exp_t model(input logic [8:0] i, input logic c, input logic [PC_W-1:0] pc);
        exp_t e;
        e    = '0;
        e.pc = pc;
        if (i[8:6] == 3'b111) begin
            e.typ = 3'd2; e.ctrl = 9'h180; e.imm = IMM_W'(i[5:0]);
        end else if (i[8:6] == 3'b101) begin
            e.typ = 3'd4; e.ctrl = 9'h004; e.r1 = i[5:4]; e.imm = IMM_W'(i[3:0]);
        end else if (i[8:6] == 3'b100) begin
            e.typ = 3'd4; e.ctrl = 9'h008; e.r1 = i[5:4]; e.imm = IMM_W'(i[3:0]);
        end else if (i[8:6] == 3'b110) begin
            e.typ = 3'd1; e.ctrl = 9'h021; e.funct = 4'h3; e.r1 = i[5:4]; e.imm = IMM_W'(i[3:0]);
        end else if (i[8:6] == 3'b011) begin
            e.typ = 3'd1; e.ctrl = 9'h021; e.r1 = i[4:3]; e.imm = IMM_W'(i[2:0]);
            e.funct = i[5] ? 4'h7 : 4'hE;
        end else if (i[8:4] == 5'b01011) begin
            e.typ = 3'd2;
            if (c) begin e.ctrl = 9'h080; e.imm = IMM_W'(i[3:0]); end
        end else if (i == 9'h001) begin
            e.typ = 3'd2;
        end else if (i[8:2] == 7'b0000000) begin
            e.typ = 3'd2;
        end else if (i[8:2] == 7'b0000011) begin
            e.typ = 3'd1; e.ctrl = 9'h021; e.funct = 4'h5; e.imm = 1; e.r1 = i[1:0];
        end else if (i[8:2] == 7'b0000010) begin
            e.typ = 3'd3; e.ctrl = 9'h041; e.r1 = i[1:0];
        end else if (i[8:2] == 7'b0000001) begin
            e.r1 = i[1:0];
            e.typ  = c ? 3'd3 : 3'd2;
            e.ctrl = c ? 9'h041 : 9'h001;
        end else begin
            e.r1 = i[3:2]; e.r2 = i[1:0]; e.ctrl = 9'h003;
            if (i[7:4] == 4'h9)      e.typ = 3'd5;
            else if (i[7:4] == 4'h8) e.typ = 3'd6;
            else if (i[7:4] == 4'h7) begin e.typ = 3'd4; e.ctrl = 9'h013; end
            else begin e.typ = 3'd1; e.funct = i[7:4]; end
        end
        return e;
    endfunction

    task automatic drive(input bit v, input logic [8:0] i, input logic [PC_W-1:0] p, input bit c);
        in_valid = v;
        in_inst  = i;
        in_pc    = p;
        cmp      = c;
    endtask

    // One clock: check handshake outputs, score any pop, record any accept,
    // then advance to the next falling edge.
    task automatic cycle();
        exp_t e;
        bit   acc;
        bit   pp;
        #1;
        check("in_ready", 64'(in_ready), 64'(m_ready));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check("halted", 64'(halted), 64'(m_halted));
        acc = in_valid && m_ready && !flush;
        pp  = (sb.size() != 0) && out_ready && !flush;
        if (pp) begin
            e = sb.pop_front();
            check("head", 64'({out_pc, out_type, out_funct, out_r1, out_r2, out_imm, out_ctrl}), 64'(e));
        end
        if (flush) sb.delete();
        if (acc) begin
            sb.push_back(model(in_inst, cmp, in_pc));
            if (in_inst == 9'h001) m_halted = 1'b1;
        end
        m_ready = !m_halted && (sb.size() < 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset raised between clock edges.
    task automatic do_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_halted"}, 64'(halted), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_fields"}, 64'({out_pc, out_type, out_funct, out_r1, out_r2, out_imm, out_ctrl}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_halted = 1'b0;
        m_ready  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    stim_t batch [15];

    initial begin
        batch = '{
            '{9'h1C5, 1'b0}, '{9'h16A, 1'b0}, '{9'h113, 1'b0}, '{9'h1BF, 1'b0},
            '{9'h0F5, 1'b0}, '{9'h0CB, 1'b0}, '{9'h002, 1'b0}, '{9'h00E, 1'b0},
            '{9'h00B, 1'b0}, '{9'h005, 1'b1}, '{9'h005, 1'b0}, '{9'h09D, 1'b0},
            '{9'h086, 1'b0}, '{9'h079, 1'b0}, '{9'h01F, 1'b0}
        };

        // Reset state while rst is high
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_fields", 64'({out_pc, out_type, out_funct, out_r1, out_r2, out_imm, out_ctrl}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // add r1,r2 appears at the head the next cycle
        out_ready = 1'b1;
        drive(1, 9'h026, 8'h10, 0);
        cycle();
        drive(0, 9'h000, 8'h00, 0);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_type", 64'(out_type), 64'd1);
        check("add_funct", 64'(out_funct), 64'd2);
        check("add_r1", 64'(out_r1), 64'd1);
        check("add_r2", 64'(out_r2), 64'd2);
        check("add_ctrl", 64'(out_ctrl), 64'h003);

        // beqi taken then not taken
        drive(1, 9'h0B5, 8'h11, 1);
        cycle();
        check("beqi_t_imm", 64'(out_imm), 64'd5);
        check("beqi_t_bri", 64'(out_ctrl[7]), 64'd1);
        drive(1, 9'h0B5, 8'h12, 0);
        cycle();
        check("beqi_n_ctrl", 64'(out_ctrl), 64'd0);
        check("beqi_n_type", 64'(out_type), 64'd2);

        // Streaming through every instruction class
        for (int k = 0; k < 15; k++) begin
            drive(1, batch[k].inst, 8'(8'h20 + k), batch[k].c);
            cycle();
        end
        drive(0, 9'h000, 8'h00, 0);
        cycle();
        cycle();

        // Back-pressure: two accepted, third waits
        out_ready = 1'b0;
        drive(1, 9'h09D, 8'h40, 0); cycle();
        drive(1, 9'h086, 8'h41, 0); cycle();
        drive(1, 9'h079, 8'h42, 0); cycle();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        cycle();
        check("bp_ready_rise", 64'(in_ready), 64'd1);
        cycle();
        drive(0, 9'h000, 8'h00, 0);
        cycle();
        cycle();

        // Flush with two buffered and fetch still presenting
        out_ready = 1'b0;
        drive(1, 9'h026, 8'h50, 0); cycle();
        drive(1, 9'h1BF, 8'h51, 0); cycle();
        drive(1, 9'h0F5, 8'h52, 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(0, 9'h000, 8'h00, 0);
        check("flush_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        cycle();
        cycle();

        // HALT accepted in the same cycle as flush is discarded
        drive(1, 9'h001, 8'h58, 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(0, 9'h000, 8'h00, 0);
        check("flush_halt", 64'(halted), 64'd0);
        cycle();
        check("flush_halt_ready", 64'(in_ready), 64'd1);

        // HALT: buffered entries still drain, intake stays closed
        out_ready = 1'b0;
        drive(1, 9'h026, 8'h60, 0); cycle();
        drive(1, 9'h001, 8'h61, 0); cycle();
        drive(1, 9'h0F5, 8'h62, 0);
        cycle();
        check("halt_flag", 64'(halted), 64'd1);
        check("halt_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8 && sb.size() != 0; k++) cycle();
        check("halt_drained", 64'(out_valid), 64'd0);
        for (int k = 0; k < 3; k++) cycle();
        check("halt_ready_hold", 64'(in_ready), 64'd0);
        drive(0, 9'h000, 8'h00, 0);
        do_reset("rst_halt");
        cycle();

        // Asynchronous reset with two entries buffered
        out_ready = 1'b0;
        drive(1, 9'h113, 8'h70, 0); cycle();
        drive(1, 9'h001, 8'h71, 0); cycle();
        drive(0, 9'h000, 8'h00, 0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_halted", 64'(halted), 64'd1);
        do_reset("rst_async");
        out_ready = 1'b1;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
